uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Synthesizable UART receiver: the receiving end of the serial link the CPU top drives on its Tx pin.
- Used by the simulation harness to capture program output as bytes; also the basis for the board-side Rx path.
- 16x oversampling, optional parity, sticky error flags and a show-ahead byte FIFO with a pop interface.

Parameters:
SYS_CLK_FREQ, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line bit rate
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1)
FIFO_AW, 2, FIFO depth = 2**FIFO_AW bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop FIFO head; ignored when rx_empty=1
clr_err  in  1  clear all sticky error flags
rd_data  out  8  FIFO head (show-ahead); 0 when empty
rx_empty  out  1  FIFO empty
overrun  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch

Behaviour:
- One clock, clk; reset is synchronous and active-high, port rst.
- Reset: rx_empty=1, rd_data=0, overrun=frame_err=parity_err=0, FSM=IDLE, FIFO pointers 0, synchronizer flops=1, tick counter=0.
- rx passes through a 2-flop synchronizer (rx_s); all sampling uses rx_s.
- Tick generator: DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer division, minimum 1. Counter runs 0..DIV-1 freely; tick is asserted on the cycle the counter equals DIV-1. All FSM actions below occur only on tick cycles.
- Sample counter: scnt, 4 bits; bit index: bidx, 0..7. Data is 8 bits, LSB first.
- FSM states:
  - IDLE: rx_s=0 -> START, scnt=0.
  - START: scnt increments each tick. At scnt=7 (bit midpoint): rx_s=0 -> DATA with scnt=0, bidx=0; rx_s=1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: at scnt=15, shift rx_s into bit 7 of the shift register (shift right). After bidx=7 -> PARITY if PARITY_EN, else STOP. scnt wraps to 0.
  - PARITY: at scnt=15, pbad = (^data ^ rx_s ^ PARITY_ODD) != 0 -> STOP.
  - STOP: at scnt=15:
    - rx_s=1 and !pbad: push the byte -> IDLE.
    - rx_s=1 and pbad: parity_err=1, byte discarded -> IDLE.
    - rx_s=0: frame_err=1, byte discarded -> WAIT_HI.
  - WAIT_HI: stay until rx_s=1, then -> IDLE. A held-low line (break) produces exactly one frame_err and no bytes.
- Push latency: the byte is visible on rd_data with rx_empty=0 on the cycle after the stop-sample tick.
- FIFO:
  - Circular buffer with a (FIFO_AW+1)-bit count.
  - Push while full: the new byte is dropped and overrun=1.
  - Push and rd_en on the same cycle while full: pop and push are both performed; overrun is not set.
  - Push and pop while empty: push only (rd_en is ignored when empty).
  - rd_data updates on the cycle after a pop.
- Sticky flags hold until clr_err=1 (cleared the next cycle) or rst. If a set event and clr_err occur on the same cycle, set wins.
- rst mid-frame aborts the frame, flushes the FIFO and clears flags. No partial byte is pushed.

Test Plan:
- SYS_CLK_FREQ=1600000, BAUD_RATE=100000 (16 clk/bit). Send 0xA5 8N1 -> rx_empty falls and rd_data=0xA5 one cycle after the stop-midpoint tick. Pulse rd_en for 1 cycle -> rx_empty=1, no flags set.
- Drive rx low for 4 clk, then high -> FSM returns to IDLE, rx_empty stays 1, no flags set.
- Send 0x3C with stop bit 0, hold rx low 100 clk, release, then send 0x11 -> frame_err=1, exactly one byte, 0x11, received.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err=1, FIFO empty. Send 0x07 with parity bit 1 -> byte 0x07 received. Pulse clr_err -> parity_err=0.
- FIFO_AW=2: send 0x01..0x05 without reading -> overrun=1; reads return 0x01, 0x02, 0x03, 0x04, then rx_empty=1.
- Assert rst for 1 cycle at data bit 3 of a frame -> all outputs at reset values. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with optional parity, sticky errors and show-ahead byte FIFO (ports: clk, rst, rx, rd_en, clr_err -> rd_data, rx_empty, overrun, frame_err, parity_err)
module uart_rx #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_empty,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int TW      = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << FIFO_AW;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] sh_q, sh_d;
  logic pbad_q, pbad_d;
  logic [7:0] mem_q [DEPTH], mem_d [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic tick, push, set_fe, set_pe, pop, full, wr;
  always_comb begin
    tick = tcnt_q == TW'(DIV - 1);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    state_d = state_q;
    scnt_d = scnt_q;
    bidx_d = bidx_q;
    sh_d = sh_q;
    pbad_d = pbad_q;
    push = 1'b0;
    set_fe = 1'b0;
    set_pe = 1'b0;
    if (tick)
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_d = START;
          scnt_d = '0;
        end
        START: begin
          scnt_d = scnt_q + 4'd1;
          // start bit re-checked at its midpoint; from here every sample lands mid-bit
          if (scnt_q == 4'd7) begin
            state_d = rx_s_q ? IDLE : DATA;
            scnt_d = '0;
            bidx_d = '0;
            pbad_d = 1'b0;
          end
        end
        DATA: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            sh_d = {rx_s_q, sh_q[7:1]};
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = PARITY_EN != 0 ? PARITY : STOP;
          end
        end
        PARITY: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            pbad_d = ^sh_q ^ rx_s_q ^ 1'(PARITY_ODD);
            state_d = STOP;
          end
        end
        STOP: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            state_d = rx_s_q ? IDLE : WAIT_HI;
            push = rx_s_q && !pbad_q;
            set_pe = rx_s_q && pbad_q;
            set_fe = !rx_s_q;
          end
        end
        WAIT_HI: if (rx_s_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    pop = rd_en && cnt_q != '0;
    full = cnt_q == (FIFO_AW + 1)'(DEPTH);
    // a pop on the same cycle frees the slot, so a full FIFO can still accept
    wr = push && (!full || pop);
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = sh_q;
    wp_d = wp_q + FIFO_AW'(wr);
    rp_d = rp_q + FIFO_AW'(pop);
    cnt_d = cnt_q + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
    ovr_d = (push && !wr) ? 1'b1 : clr_err ? 1'b0 : ovr_q;
    fe_d = set_fe ? 1'b1 : clr_err ? 1'b0 : fe_q;
    pe_d = set_pe ? 1'b1 : clr_err ? 1'b0 : pe_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      tcnt_q <= '0;
      scnt_q <= '0;
      bidx_q <= '0;
      sh_q <= '0;
      pbad_q <= 1'b0;
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      tcnt_q <= tcnt_d;
      scnt_q <= scnt_d;
      bidx_q <= bidx_d;
      sh_q <= sh_d;
      pbad_q <= pbad_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      fe_q <= fe_d;
      pe_q <= pe_d;
    end
  end
  assign rx_empty = cnt_q == '0;
  assign rd_data = rx_empty ? 8'd0 : mem_q[rp_q];
  assign overrun = ovr_q;
  assign frame_err = fe_q;
  assign parity_err = pe_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx, one 8N1 instance and one even-parity instance
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1;
  logic rx0 = 1'b1, rd_en0 = 1'b0, clr0 = 1'b0;
  logic rx1 = 1'b1, rd_en1 = 1'b0, clr1 = 1'b0;
  logic [7:0] rd0, rd1;
  logic emp0, ovr0, fe0, pe0, emp1, ovr1, fe1, pe1;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_rx #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_AW(2)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd_en0), .clr_err(clr0), .rd_data(rd0),
    .rx_empty(emp0), .overrun(ovr0), .frame_err(fe0), .parity_err(pe0));
  uart_rx #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_AW(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd_en1), .clr_err(clr1), .rd_data(rd1),
    .rx_empty(emp1), .overrun(ovr1), .frame_err(fe1), .parity_err(pe1));
  typedef struct {
    bit d1; logic [7:0] b; bit par; bit stop;
    bit e_empty; logic [7:0] e_data; bit e_fe; bit e_pe;
  } vec_t;
  vec_t v [10];
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drv(input bit d1, input bit val, input int n);
    if (d1) rx1 = val; else rx0 = val;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input bit d1, input logic [7:0] b, input bit par, input bit stop, input int stop_clks);
    drv(d1, 1'b0, 16);
    for (int i = 0; i < 8; i++) drv(d1, b[i], 16);
    if (d1) drv(d1, par, 16);
    drv(d1, stop, stop_clks);
    drv(d1, 1'b1, 0);
  endtask
  task automatic pulse(input bit d1, input bit is_clr);
    if (is_clr) begin if (d1) clr1 = 1'b1; else clr0 = 1'b1; end
    else begin if (d1) rd_en1 = 1'b1; else rd_en0 = 1'b1; end
    @(posedge clk);
    #1;
    {clr0, clr1, rd_en0, rd_en1} = '0;
  endtask
  initial begin
    v[0] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0};
    v[1] = '{0, 8'hFF, 0, 1, 0, 8'hFF, 0, 0};
    v[2] = '{0, 8'h81, 0, 1, 0, 8'h81, 0, 0};
    v[3] = '{0, 8'h3C, 0, 0, 1, 8'h00, 1, 0};
    v[4] = '{1, 8'h07, 0, 1, 1, 8'h00, 0, 1};
    v[5] = '{1, 8'h07, 1, 1, 0, 8'h07, 0, 0};
    v[6] = '{1, 8'hFF, 0, 1, 0, 8'hFF, 0, 0};
    v[7] = '{1, 8'h80, 0, 1, 1, 8'h00, 0, 1};
    v[8] = '{1, 8'h80, 1, 1, 0, 8'h80, 0, 0};
    v[9] = '{1, 8'h55, 0, 0, 1, 8'h00, 1, 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_empty0", 8'(emp0), 8'd1);
    chk("rst_data0", rd0, 8'd0);
    chk("rst_flags0", {5'd0, ovr0, fe0, pe0}, 8'd0);
    chk("rst_empty1", 8'(emp1), 8'd1);
    chk("rst_flags1", {5'd0, ovr1, fe1, pe1}, 8'd0);
    repeat (4) @(posedge clk);
    #1;
    drv(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drv(0, (8'hA5 >> i) & 1'b1, 16);
    rx0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("a5_before_push", 8'(emp0), 8'd1);
    @(posedge clk);
    #1;
    chk("a5_push_empty", 8'(emp0), 8'd0);
    chk("a5_push_data", rd0, 8'hA5);
    repeat (5) @(posedge clk);
    #1;
    pulse(0, 0);
    chk("a5_pop_empty", 8'(emp0), 8'd1);
    chk("a5_pop_data", rd0, 8'd0);
    chk("a5_flags", {5'd0, ovr0, fe0, pe0}, 8'd0);
    drv(0, 1'b0, 4);
    drv(0, 1'b1, 40);
    chk("glitch_empty", 8'(emp0), 8'd1);
    chk("glitch_flags", {5'd0, ovr0, fe0, pe0}, 8'd0);
    for (int k = 0; k < 10; k++) begin
      send(v[k].d1, v[k].b, v[k].par, v[k].stop, 16);
      repeat (6) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_empty", k), 8'(v[k].d1 ? emp1 : emp0), 8'(v[k].e_empty));
      chk($sformatf("vec%0d_data", k), v[k].d1 ? rd1 : rd0, v[k].e_data);
      chk($sformatf("vec%0d_ferr", k), 8'(v[k].d1 ? fe1 : fe0), 8'(v[k].e_fe));
      chk($sformatf("vec%0d_perr", k), 8'(v[k].d1 ? pe1 : pe0), 8'(v[k].e_pe));
      if (!v[k].e_empty) pulse(v[k].d1, 0);
      pulse(v[k].d1, 1);
      chk($sformatf("vec%0d_clr", k), 8'(v[k].d1 ? {emp1, fe1, pe1} : {emp0, fe0, pe0}), 8'b100);
    end
    send(0, 8'h3C, 0, 0, 100);
    repeat (8) @(posedge clk);
    #1;
    send(0, 8'h11, 0, 1, 16);
    repeat (6) @(posedge clk);
    #1;
    chk("break_ferr", 8'(fe0), 8'd1);
    chk("break_data", rd0, 8'h11);
    pulse(0, 0);
    chk("break_one_byte", 8'(emp0), 8'd1);
    pulse(0, 1);
    chk("break_clr", 8'(fe0), 8'd0);
    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 0, 1, 16);
      if (i == 4) begin
        repeat (2) @(posedge clk);
        #1;
        chk("full_no_ovr", 8'(ovr0), 8'd0);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    chk("ovr_set", 8'(ovr0), 8'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_read%0d", i), rd0, 8'(i));
      pulse(0, 0);
    end
    chk("ovr_drain_empty", 8'(emp0), 8'd1);
    send(0, 8'h77, 0, 1, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_data", rd0, 8'h77);
    drv(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drv(0, (8'h5A >> i) & 1'b1, 16);
    drv(0, 1'b1, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_empty", 8'(emp0), 8'd1);
    chk("midrst_data", rd0, 8'd0);
    chk("midrst_flags", {5'd0, ovr0, fe0, pe0}, 8'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("midrst_no_partial", 8'(emp0), 8'd1);
    send(0, 8'h5A, 0, 1, 16);
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_data", rd0, 8'h5A);
    chk("post_rst_flags", {5'd0, ovr0, fe0, pe0}, 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
